pe_mesh: RTL and testbench

Parametrised ROWS x COLS mesh of processing elements replacing the single-cell message-passer array. Each cell holds an A operand, a B operand, and an accumulator S. A command sequencer drives the mesh through a valid/ready handshake. Supported commands: column-wise operand load from the left edge, multi-step directional shifting of either operand image, array-wide signed multiply-accumulate, accumulator clear, and row readout. The block sits between the host command interface and the PE storage and is the compute core of the accelerator.

---
 rtl/pe_mesh_pkg.sv | 22 ++
 rtl/pe_mesh_if.sv | 30 +++
 rtl/pe_mesh_cell.sv | 77 +++++++
 rtl/pe_mesh.sv | 164 ++++++++++++++++
 tb/tb_pe_mesh.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pe_mesh_pkg.sv
// rtl/pe_mesh_pkg.sv - opcodes, shift directions, image selects and FSM state type for pe_mesh
package pe_mesh_pkg;

  localparam logic [2:0] CMD_NOP    = 3'd0;
  localparam logic [2:0] CMD_LOAD_A = 3'd1;
  localparam logic [2:0] CMD_LOAD_B = 3'd2;
  localparam logic [2:0] CMD_SHIFT  = 3'd3;
  localparam logic [2:0] CMD_MAC    = 3'd4;
  localparam logic [2:0] CMD_CLEAR  = 3'd5;
  localparam logic [2:0] CMD_READ   = 3'd6;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic IMG_A = 1'b0;
  localparam logic IMG_B = 1'b1;

  typedef enum logic {ST_IDLE, ST_SHIFTING} state_t;

endpackage

// File: rtl/pe_mesh_if.sv
// rtl/pe_mesh_if.sv - command handshake and readout bundle between host sequencer and pe_mesh
interface pe_mesh_if #(
  parameter int ROWS             = 4,
  parameter int COLS             = 4,
  parameter int PRECISION        = 8,
  parameter int OUTPUT_PRECISION = 32,
  parameter int CNT_W            = 4
);
  logic                             cmd_valid;
  logic                             cmd_ready;
  logic [2:0]                       cmd;
  logic                             image_sel;
  logic [1:0]                       shift_dir;
  logic [CNT_W-1:0]                 shift_count;
  logic [ROWS*PRECISION-1:0]        load_data;
  logic [$clog2(ROWS):0]            rd_row;
  logic [COLS*OUTPUT_PRECISION-1:0] rd_data;
  logic                             rd_valid;
  logic                             done;

  modport master (
    output cmd_valid, cmd, image_sel, shift_dir, shift_count, load_data, rd_row,
    input  cmd_ready, rd_data, rd_valid, done
  );

  modport slave (
    input  cmd_valid, cmd, image_sel, shift_dir, shift_count, load_data, rd_row,
    output cmd_ready, rd_data, rd_valid, done
  );
endinterface

// File: rtl/pe_mesh_cell.sv
// rtl/pe_mesh_cell.sv - pe_cell: one mesh cell with A/B operand registers and signed MAC accumulator
module pe_cell
  import pe_mesh_pkg::*;
#(
  parameter int PRECISION        = 8,
  parameter int OUTPUT_PRECISION = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic signed [PRECISION-1:0]        a_up_i,
  input  logic signed [PRECISION-1:0]        a_dn_i,
  input  logic signed [PRECISION-1:0]        a_lf_i,
  input  logic signed [PRECISION-1:0]        a_rt_i,
  input  logic signed [PRECISION-1:0]        b_up_i,
  input  logic signed [PRECISION-1:0]        b_dn_i,
  input  logic signed [PRECISION-1:0]        b_lf_i,
  input  logic signed [PRECISION-1:0]        b_rt_i,
  input  logic signed [PRECISION-1:0]        load_in_i,
  input  logic                               shift_a_i,
  input  logic                               shift_b_i,
  input  logic [1:0]                         dir_i,
  input  logic                               load_a_i,
  input  logic                               load_b_i,
  input  logic                               mac_i,
  input  logic                               clr_i,
  output logic signed [PRECISION-1:0]        a_o,
  output logic signed [PRECISION-1:0]        b_o,
  output logic signed [OUTPUT_PRECISION-1:0] s_o
);
  logic signed [PRECISION-1:0]          a_q, a_d, b_q, b_d;
  logic signed [OUTPUT_PRECISION-1:0]   s_q, s_d, prod_ext;
  logic signed [2*PRECISION-1:0]        prod;

  // Up takes the value from the row below, left from the column to the right.
  function automatic logic signed [PRECISION-1:0] pick(
    input logic [1:0] dir,
    input logic signed [PRECISION-1:0] up, dn, lf, rt
  );
    case (dir)
      DIR_UP:   pick = dn;
      DIR_DOWN: pick = up;
      DIR_LEFT: pick = rt;
      default:  pick = lf;
    endcase
  endfunction

  assign prod     = a_q * b_q;
  assign prod_ext = OUTPUT_PRECISION'(prod);

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    if (clr_i)        s_d = '0;
    else if (mac_i)   s_d = s_q + prod_ext;
    if (load_a_i)       a_d = load_in_i;
    else if (shift_a_i) a_d = pick(dir_i, a_up_i, a_dn_i, a_lf_i, a_rt_i);
    if (load_b_i)       b_d = load_in_i;
    else if (shift_b_i) b_d = pick(dir_i, b_up_i, b_dn_i, b_lf_i, b_rt_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
    end
  end

  assign a_o = a_q;
  assign b_o = b_q;
  assign s_o = s_q;
endmodule

// File: rtl/pe_mesh.sv
// rtl/pe_mesh.sv - ROWS x COLS PE mesh with command FSM, neighbour wiring and row readout
// Define PE_MESH_WRAP_EN for toroidal shifting instead of zero fill.
module pe_mesh
  import pe_mesh_pkg::*;
#(
  parameter int ROWS             = 4,
  parameter int COLS             = 4,
  parameter int PRECISION        = 8,
  parameter int OUTPUT_PRECISION = 32,
  parameter int CNT_W            = 4
) (
  input logic      CLK,
  input logic      RST,
  pe_mesh_if.slave bus
);
`ifdef PE_MESH_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
  localparam int P  = PRECISION;
  localparam int OP = OUTPUT_PRECISION;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sel_q, sel_d;
  logic [1:0]           dir_q, dir_d;
  logic                 done_q, done_d, rd_valid_q, rd_valid_d;
  logic [COLS*OP-1:0]   rd_data_q, rd_data_d, row_sel;

  logic                 accept, shift_now, step_sel;
  logic [1:0]           step_dir;
  logic                 shift_a, shift_b, load_a, load_b, mac, clr;

  logic signed [P-1:0]  a_img [ROWS][COLS];
  logic signed [P-1:0]  b_img [ROWS][COLS];
  logic signed [OP-1:0] s_img [ROWS][COLS];

  assign bus.cmd_ready = (state_q == ST_IDLE) && !RST;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // The first SHIFT step happens on the accept edge, so sideband is used directly there.
  assign shift_now = (state_q == ST_SHIFTING) ||
                     (accept && bus.cmd == CMD_SHIFT && bus.shift_count != '0);
  assign step_sel  = (state_q == ST_SHIFTING) ? sel_q : bus.image_sel;
  assign step_dir  = (state_q == ST_SHIFTING) ? dir_q : bus.shift_dir;
  assign shift_a   = shift_now && step_sel == IMG_A;
  assign shift_b   = shift_now && step_sel == IMG_B;
  assign load_a    = accept && bus.cmd == CMD_LOAD_A;
  assign load_b    = accept && bus.cmd == CMD_LOAD_B;
  assign mac       = accept && bus.cmd == CMD_MAC;
  assign clr       = accept && bus.cmd == CMD_CLEAR;

  always_comb begin
    row_sel = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (int'(bus.rd_row) == r) begin
        for (int c = 0; c < COLS; c++) row_sel[c*OP +: OP] = s_img[r][c];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    dir_d      = dir_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          done_d = 1'b1;
          if (bus.cmd == CMD_SHIFT) begin
            sel_d = bus.image_sel;
            dir_d = bus.shift_dir;
            cnt_d = bus.shift_count;
            if (bus.shift_count > CNT_W'(1)) begin
              state_d = ST_SHIFTING;
              cnt_d   = bus.shift_count - CNT_W'(1);
              done_d  = 1'b0;
            end
          end else if (bus.cmd == CMD_READ) begin
            rd_valid_d = 1'b1;
            rd_data_d  = row_sel;
          end
        end
      end
      default: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sel_q      <= 1'b0;
      dir_q      <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      dir_q      <= dir_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.done     = done_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int RA = (r == 0) ? ROWS-1 : r-1;
      localparam int RB = (r == ROWS-1) ? 0 : r+1;
      localparam int CL = (c == 0) ? COLS-1 : c-1;
      localparam int CR = (c == COLS-1) ? 0 : c+1;
      localparam bit ZA = (r == 0) && !WRAP_EN;
      localparam bit ZB = (r == ROWS-1) && !WRAP_EN;
      localparam bit ZL = (c == 0) && !WRAP_EN;
      localparam bit ZR = (c == COLS-1) && !WRAP_EN;

      logic signed [P-1:0] a_up, a_dn, a_lf, a_rt, b_up, b_dn, b_lf, b_rt, ld_in;

      assign a_up = ZA ? '0 : a_img[RA][c];
      assign a_dn = ZB ? '0 : a_img[RB][c];
      assign a_lf = ZL ? '0 : a_img[r][CL];
      assign a_rt = ZR ? '0 : a_img[r][CR];
      assign b_up = ZA ? '0 : b_img[RA][c];
      assign b_dn = ZB ? '0 : b_img[RB][c];
      assign b_lf = ZL ? '0 : b_img[r][CL];
      assign b_rt = ZR ? '0 : b_img[r][CR];

      // Loads always enter at column 0, regardless of wrap.
      if (c == 0) begin : g_edge
        assign ld_in = bus.load_data[r*P +: P];
      end else begin : g_inner
        assign ld_in = (bus.cmd == CMD_LOAD_B) ? b_img[r][CL] : a_img[r][CL];
      end

      pe_cell #(.PRECISION(P), .OUTPUT_PRECISION(OP)) u_cell (
        .clk_i(CLK), .rst_i(RST),
        .a_up_i(a_up), .a_dn_i(a_dn), .a_lf_i(a_lf), .a_rt_i(a_rt),
        .b_up_i(b_up), .b_dn_i(b_dn), .b_lf_i(b_lf), .b_rt_i(b_rt),
        .load_in_i(ld_in),
        .shift_a_i(shift_a), .shift_b_i(shift_b), .dir_i(step_dir),
        .load_a_i(load_a), .load_b_i(load_b), .mac_i(mac), .clr_i(clr),
        .a_o(a_img[r][c]), .b_o(b_img[r][c]), .s_o(s_img[r][c])
      );
    end
  end
endmodule

// File: tb/tb_pe_mesh.sv
// tb/tb_pe_mesh.sv - scoreboard bench for a 3x3 pe_mesh; expectations follow PE_MESH_WRAP_EN
module tb_pe_mesh;
  import pe_mesh_pkg::*;

  localparam int ROWS = 3, COLS = 3, P = 8, OP = 32, CNT_W = 4;
  localparam int RW = $clog2(ROWS) + 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  pe_mesh_if #(.ROWS(ROWS), .COLS(COLS), .PRECISION(P), .OUTPUT_PRECISION(OP), .CNT_W(CNT_W)) bus ();

  pe_mesh #(.ROWS(ROWS), .COLS(COLS), .PRECISION(P), .OUTPUT_PRECISION(OP), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  typedef struct {
    int                 cyc;
    bit                 rd;
    logic [COLS*OP-1:0] data;
    string              nm;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  function automatic logic [ROWS*P-1:0] col3(input int v0, input int v1, input int v2);
    logic [ROWS*P-1:0] v;
    v = {P'(v2), P'(v1), P'(v0)};
    return v;
  endfunction

  function automatic logic [COLS*OP-1:0] row3(input int s0, input int s1, input int s2);
    logic [COLS*OP-1:0] v;
    v = {OP'(s2), OP'(s1), OP'(s0)};
    return v;
  endfunction

  task automatic check(input string nm, input logic [COLS*OP-1:0] act, input logic [COLS*OP-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.done || bus.rd_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pulse cycle=%0d done=%0b rd_valid=%0b required=no_pulse",
                 cyc, bus.done, bus.rd_valid);
      end else begin
        e = sbq.pop_front();
        check({e.nm, "_cycle"}, (COLS*OP)'(cyc), (COLS*OP)'(e.cyc));
        check({e.nm, "_done"}, (COLS*OP)'(bus.done), (COLS*OP)'(1));
        check({e.nm, "_rd_valid"}, (COLS*OP)'(bus.rd_valid), (COLS*OP)'(e.rd));
        if (e.rd) check({e.nm, "_rd_data"}, bus.rd_data, e.data);
      end
    end
  end

  task automatic issue(input logic [2:0] c, input logic sel, input logic [1:0] dir, input int cnt,
                       input logic [ROWS*P-1:0] ld, input int row, output int k);
    int waited;
    @(negedge CLK);
    bus.cmd         = c;
    bus.image_sel   = sel;
    bus.shift_dir   = dir;
    bus.shift_count = CNT_W'(cnt);
    bus.load_data   = ld;
    bus.rd_row      = RW'(row);
    bus.cmd_valid   = 1'b1;
    waited = 0;
    while (!bus.cmd_ready && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout cmd=%0d cmd_ready=%0b required=1", c, bus.cmd_ready);
    end
    k = cyc + 1;
    @(posedge CLK);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic op(input logic [2:0] c, input logic sel, input logic [1:0] dir, input int cnt,
                    input logic [ROWS*P-1:0] ld, input int row, input logic [COLS*OP-1:0] exp_data,
                    input string nm, output int k);
    exp_t x;
    issue(c, sel, dir, cnt, ld, row, k);
    x.cyc  = (c == CMD_SHIFT && cnt >= 1) ? k + cnt - 1 : k;
    x.rd   = (c == CMD_READ);
    x.data = exp_data;
    x.nm   = nm;
    sbq.push_back(x);
  endtask

  task automatic simple(input logic [2:0] c, input logic [ROWS*P-1:0] ld, input string nm);
    int k;
    op(c, IMG_A, DIR_UP, 0, ld, 0, '0, nm, k);
  endtask

  task automatic rd(input int row, input logic [COLS*OP-1:0] exp_data, input string nm);
    int k;
    op(CMD_READ, IMG_A, DIR_UP, 0, '0, row, exp_data, nm, k);
  endtask

  task automatic load_a_image();
    simple(CMD_LOAD_A, col3(3, 6, 9), "load_a_c2");
    simple(CMD_LOAD_A, col3(2, 5, 8), "load_a_c1");
    simple(CMD_LOAD_A, col3(1, 4, 7), "load_a_c0");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    int k_sh, k_nop, k_tmp;
    bus.cmd_valid = 1'b0; bus.cmd = '0; bus.image_sel = 1'b0; bus.shift_dir = '0;
    bus.shift_count = '0; bus.load_data = '0; bus.rd_row = '0;

    repeat (2) @(negedge CLK);
    check("rst_cmd_ready", (COLS*OP)'(bus.cmd_ready), '0);
    check("rst_done", (COLS*OP)'(bus.done), '0);
    check("rst_rd_valid", (COLS*OP)'(bus.rd_valid), '0);
    RST = 1'b0;
    #1 check("rst_release_ready", (COLS*OP)'(bus.cmd_ready), (COLS*OP)'(1));
    rd(0, '0, "rst_read_s0");

    // A(r,c)=3r+c+1, B(r,c)=c+1, back-to-back loads
    load_a_image();
    simple(CMD_LOAD_B, col3(3, 3, 3), "load_b_c2");
    simple(CMD_LOAD_B, col3(2, 2, 2), "load_b_c1");
    simple(CMD_LOAD_B, col3(1, 1, 1), "load_b_c0");
    simple(CMD_CLEAR, '0, "clear0");
    simple(CMD_MAC, '0, "mac0");
    rd(0, row3(1, 4, 9), "load_row0");
    rd(1, row3(4, 10, 18), "load_row1");
    rd(2, row3(7, 16, 27), "load_row2");

    op(CMD_SHIFT, IMG_A, DIR_RIGHT, 2, '0, 0, '0, "shift_r2", k_sh);
    op(CMD_NOP, IMG_A, DIR_UP, 0, '0, 0, '0, "nop_after_shift", k_nop);
    check("shift_held_accept", (COLS*OP)'(k_nop), (COLS*OP)'(k_sh + 2));
    simple(CMD_CLEAR, '0, "clear1");
    simple(CMD_MAC, '0, "mac1");
`ifdef PE_MESH_WRAP_EN
    rd(0, row3(2, 6, 3), "shift_r2_row0");
    rd(2, row3(8, 18, 21), "shift_r2_row2");
`else
    rd(0, row3(0, 0, 3), "shift_r2_row0");
    rd(2, row3(0, 0, 21), "shift_r2_row2");
`endif

    op(CMD_SHIFT, IMG_A, DIR_LEFT, 0, '0, 0, '0, "shift_n0", k_tmp);
    simple(CMD_CLEAR, '0, "clear2");
    simple(CMD_MAC, '0, "mac2");
`ifdef PE_MESH_WRAP_EN
    rd(1, row3(5, 12, 12), "shift_n0_row1");
`else
    rd(1, row3(0, 0, 12), "shift_n0_row1");
`endif

    load_a_image();
    op(CMD_SHIFT, IMG_A, DIR_UP, 1, '0, 0, '0, "shift_up1", k_tmp);
    simple(CMD_CLEAR, '0, "clear3");
    simple(CMD_MAC, '0, "mac3");
    rd(0, row3(4, 10, 18), "shift_up_row0");
`ifdef PE_MESH_WRAP_EN
    rd(2, row3(1, 4, 9), "shift_up_row2");
`else
    rd(2, row3(0, 0, 0), "shift_up_row2");
`endif

    for (int i = 0; i < 3; i++) simple(CMD_LOAD_A, col3(-3, -3, -3), "load_a_neg");
    for (int i = 0; i < 3; i++) simple(CMD_LOAD_B, col3(5, 5, 5), "load_b_five");
    simple(CMD_CLEAR, '0, "clear4");
    simple(CMD_MAC, '0, "mac4a");
    simple(CMD_MAC, '0, "mac4b");
    rd(1, {3{32'hFFFFFFE2}}, "mac_signed_row1");
    rd(ROWS, '0, "read_out_of_range");
    simple(CMD_CLEAR, '0, "clear5");
    rd(0, '0, "clear_row0");
    simple(CMD_MAC, '0, "mac5");
    rd(2, {3{32'hFFFFFFF1}}, "clear_keeps_ab");
    simple(CMD_NOP, '0, "nop7");

    // reset two cycles into a 3-step shift: no done may follow
    issue(CMD_SHIFT, IMG_A, DIR_DOWN, 3, '0, 0, k_tmp);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_mid_ready_low", (COLS*OP)'(bus.cmd_ready), '0);
    @(negedge CLK);
    RST = 1'b0;
    #1 check("rst_mid_ready_high", (COLS*OP)'(bus.cmd_ready), (COLS*OP)'(1));
    rd(0, '0, "rst_mid_row0");
    simple(CMD_MAC, '0, "mac6");
    rd(1, '0, "rst_mid_ab_zero");

    repeat (5) @(negedge CLK);
    check("scoreboard_drained", (COLS*OP)'(sbq.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
